// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with arbitrary depth, registered or
// first-word-fall-through output, programmable almost flags, and sticky
// overflow/underflow error flags.
module sync_fifo_flex #(
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 512,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    // Reject parameter combinations the datapath cannot honour.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo_flex: FWFT must be 0 or 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR-1:0]  rd_ptr_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             do_write, do_read;

    // Pointer increment with an explicit wrap at DEPTH-1, so non-power-of-two
    // depths never index past the last storage word.
    function automatic logic [ADDR-1:0] ptr_inc(input logic [ADDR-1:0] p);
        if (p == ADDR'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));

    assign count     = count_q;
    assign dout      = dout_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Accept/pointer/occupancy/error-flag next state from pre-edge state.
    always_comb begin
        do_write   = wr_en && !full;
        do_read    = rd_en && !empty;
        rd_ptr_nxt = ptr_inc(rd_ptr_q);

        wr_ptr_d = do_write ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_read  ? rd_ptr_nxt        : rd_ptr_q;

        count_d = count_q;
        case ({do_write, do_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event wins over a clear in the same cycle.
        overflow_d = overflow_q;
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    // Output word selection. In FWFT mode dout_q is a copy of the head word
    // (storage still holds it), so capacity stays exactly DEPTH; it is only
    // reloaded when the head changes, which leaves the last popped value
    // visible once the FIFO drains.
    always_comb begin
        dout_d = dout_q;
        if (FWFT == 1) begin
            if (do_read) begin
                if (count_q > CW'(1)) begin
                    dout_d = mem_q[rd_ptr_nxt];
                end else if (do_write) begin
                    dout_d = din;
                end
            end else if (do_write && empty) begin
                dout_d = din;
            end
        end else begin
            if (do_read) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end
    end

    // Control and output registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!srst && do_write) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
